pe_vec_mac: RTL

Vector multiply-accumulate processing element, the successor to the single-lane PE. Each accepted beat carries `LANES` signed activation/weight pairs. The block multiplies them, reduces them through a registered adder tree, and accumulates across beats up to `in_last`. It then presents one partial sum on a valid/ready output. It sits between the line-buffer/weight-feed stage and the channel adder, replacing per-lane PEs plus external summing.

---
 rtl/pe_pkg.sv | 53 +++++
 rtl/pe_adder_tree.sv | 48 ++++
 rtl/pe_vec_mac.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared types and width helpers for the vector MAC processing element:
// FSM state encoding, derived datapath widths and the output clamp helpers.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } pe_state_t;

  localparam int SAT_W = 64;

  function automatic int prod_w(input int in_w);
    return 2 * in_w;
  endfunction

  function automatic int sum_w(input int in_w, input int lanes);
    return prod_w(in_w) + $clog2(lanes);
  endfunction

  function automatic int acc_w(input int in_w, input int lanes, input int max_beats);
    return sum_w(in_w, lanes) + $clog2(max_beats);
  endfunction

  // Clamp a wide signed value into the signed range of out_w bits.
  function automatic logic signed [SAT_W-1:0] sat_clamp(input logic signed [SAT_W-1:0] v,
                                                        input int out_w);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = 1;
    hi  = (one <<< (out_w - 1)) - one;
    lo  = -hi - one;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

  function automatic logic sat_hit(input logic signed [SAT_W-1:0] v, input int out_w);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = 1;
    hi  = (one <<< (out_w - 1)) - one;
    lo  = -hi - one;
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/pe_adder_tree.sv
// Balanced signed reduction of LANES packed operands with a registered result.
// Operand count is padded with zeros to the next power of two.
module pe_adder_tree #(
  parameter int LANES = 4,
  parameter int IN_W  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [LANES*IN_W-1:0]                  lanes_i,
  output logic signed [IN_W+$clog2(LANES)-1:0]   sum_o
);

  localparam int OUT_W  = IN_W + $clog2(LANES);
  localparam int LEVELS = $clog2(LANES);
  localparam int N2     = 1 << LEVELS;
  localparam int PAD_W  = N2 * IN_W;

  logic [PAD_W-1:0]        padded;
  logic signed [OUT_W-1:0] node_v [N2];
  logic signed [OUT_W-1:0] sum_d;
  logic signed [OUT_W-1:0] sum_q;

  assign padded = PAD_W'(lanes_i);

  // Pairwise halving keeps the combinational depth at log2(LANES) adders.
  always_comb begin
    for (int i = 0; i < N2; i++) begin
      node_v[i] = OUT_W'($signed(padded[i*IN_W +: IN_W]));
    end
    for (int w = N2 / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        node_v[i] = node_v[2*i] + node_v[2*i+1];
      end
    end
    sum_d = node_v[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/pe_vec_mac.sv
// Vector MAC PE: LANES products -> registered adder tree -> window accumulator,
// result held on a valid/ready port. Define PE_SATURATE_EN to clamp instead of wrap.
module pe_vec_mac
  import pe_pkg::*;
#(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 20,
  parameter int LANES        = 4,
  parameter int MAX_BEATS    = 9
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  input  logic [LANES*INPUT_WIDTH-1:0]    ifm_input,
  input  logic [LANES*INPUT_WIDTH-1:0]    wgt_input,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [OUTPUT_WIDTH-1:0]  psum_output,
  output logic                            err_len,
  output logic                            sat_flag
);

  localparam int PROD_W = prod_w(INPUT_WIDTH);
  localparam int SUM_W  = sum_w(INPUT_WIDTH, LANES);
  localparam int ACC_W  = acc_w(INPUT_WIDTH, LANES, MAX_BEATS);
  localparam int CNT_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  pe_state_t          state_q, state_d;
  logic               drain_q, drain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               accept;
  logic               at_max;

  logic [LANES*PROD_W-1:0] prod_d, prod_q;
  logic                    s1_valid_q, s1_first_q;
  logic                    s2_valid_q, s2_first_q;
  logic signed [SUM_W-1:0] s2_sum;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  assign accept = in_valid && in_ready_q;
  assign at_max = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    err_len = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (in_last || at_max) begin
            state_d = DRAIN;
            drain_d = 1'b0;
            cnt_d   = '0;
            err_len = !in_last;
          end else begin
            state_d = ACCUM;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = HOLD;
        end else begin
          drain_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE) || (state_d == ACCUM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      drain_q    <= 1'b0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == HOLD);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [INPUT_WIDTH-1:0] act;
    logic signed [INPUT_WIDTH-1:0] wgt;
    assign act = ifm_input[gi*INPUT_WIDTH +: INPUT_WIDTH];
    assign wgt = wgt_input[gi*INPUT_WIDTH +: INPUT_WIDTH];
    assign prod_d[gi*PROD_W +: PROD_W] = PROD_W'(act) * PROD_W'(wgt);
  end

  // The first-beat tag travels with the data so S3 knows when to load rather than add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      if (accept) begin
        prod_q <= prod_d;
      end
      s1_valid_q <= accept;
      s1_first_q <= accept && (cnt_q == '0);
      s2_valid_q <= s1_valid_q;
      s2_first_q <= s1_first_q;
      acc_q      <= acc_d;
    end
  end

  pe_adder_tree #(
    .LANES (LANES),
    .IN_W  (PROD_W)
  ) u_tree (
    .clk     (clk),
    .rst     (rst),
    .lanes_i (prod_q),
    .sum_o   (s2_sum)
  );

  always_comb begin
    acc_d = acc_q;
    if (s2_valid_q) begin
      acc_d = s2_first_q ? ACC_W'(s2_sum) : acc_q + ACC_W'(s2_sum);
    end
  end

  if (OUTPUT_WIDTH >= ACC_W) begin : g_out_ext
    assign psum_output = OUTPUT_WIDTH'(acc_q);
    assign sat_flag    = 1'b0;
  end else begin : g_out_narrow
`ifdef PE_SATURATE_EN
    logic signed [SAT_W-1:0] acc_wide;
    assign acc_wide    = SAT_W'(acc_q);
    assign psum_output = OUTPUT_WIDTH'(sat_clamp(acc_wide, OUTPUT_WIDTH));
    assign sat_flag    = sat_hit(acc_wide, OUTPUT_WIDTH);
`else
    assign psum_output = acc_q[OUTPUT_WIDTH-1:0];
    assign sat_flag    = 1'b0;
`endif
  end

endmodule
